// File: rtl/sod_board_ctrl.sv
// Player-side sudoku board controller: holds the player board, cursor,
// placement checking, mistake count and the win/loss state machine.
// Optional feature macro: SOD_HINT_EN adds a once-per-game hint input and a
// hintUsed output.
//
// state | meaning
// LOAD  | one cycle for the answer key to settle; reload clues, clear game
// PLAY  | player moves the cursor and places symbols
// CHECK | scan the full board against the key, one cell per cycle
// WON   | sticky, clean scan
// LOST  | sticky, too many mistakes or scan mismatch
module sod_board_ctrl #(
  parameter int unsigned MAX_MISTAKES = 3,
  parameter logic [15:0] CLUE_MASK    = 16'hA5A5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   newGame,
  input  logic [3:0][3:0][1:0]   cardArray,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic                   place,
  input  logic [1:0]             sel,
`ifdef SOD_HINT_EN
  input  logic                   hint,
  output logic                   hintUsed,
`endif
  output logic [1:0]             cursorRow,
  output logic [1:0]             cursorCol,
  output logic [3:0][3:0][1:0]   board,
  output logic [15:0]            filled,
  output logic [1:0]             mistakes,
  output logic                   wrongFlash,
  output logic                   playing,
  output logic                   won,
  output logic                   lost
);

  typedef enum logic [2:0] {S_LOAD, S_PLAY, S_CHECK, S_WON, S_LOST} state_t;

  localparam logic [1:0] MAX_M = 2'(MAX_MISTAKES);

  state_t               state_q, state_d;
  logic [1:0]           row_q, row_d, col_q, col_d;
  logic [3:0][3:0][1:0] board_q, board_d;
  logic [15:0]          filled_q, filled_d;
  logic [1:0]           mistakes_q, mistakes_d;
  logic                 flash_q, flash_d;
  logic [3:0]           scan_q, scan_d;
`ifdef SOD_HINT_EN
  logic                 hint_used_q, hint_used_d;
  logic                 hint_req;
  assign hint_req = hint;
`endif

  logic [3:0] cur_idx;
  logic [1:0] cur_key;
  logic       do_place;

  assign cur_idx = {row_q, col_q};
  assign cur_key = cardArray[row_q][col_q];

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      board_q    <= '0;
      filled_q   <= 16'd0;
      mistakes_q <= 2'd0;
      flash_q    <= 1'b0;
      scan_q     <= 4'd0;
`ifdef SOD_HINT_EN
      hint_used_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      board_q    <= board_d;
      filled_q   <= filled_d;
      mistakes_q <= mistakes_d;
      flash_q    <= flash_d;
      scan_q     <= scan_d;
`ifdef SOD_HINT_EN
      hint_used_q <= hint_used_d;
`endif
    end
  end

  // Next-state logic: game flow, cursor moves, placement and board scan
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    board_d    = board_q;
    filled_d   = filled_q;
    mistakes_d = mistakes_q;
    flash_d    = 1'b0;
    scan_d     = scan_q;
    do_place   = 1'b0;
`ifdef SOD_HINT_EN
    hint_used_d = hint_used_q;
`endif
    if (newGame) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              board_d[r][c] = CLUE_MASK[r*4+c] ? cardArray[r][c] : 2'b00;
          filled_d   = CLUE_MASK;
          mistakes_d = 2'd0;
          row_d      = 2'd0;
          col_d      = 2'd0;
`ifdef SOD_HINT_EN
          hint_used_d = 1'b0;
`endif
          state_d    = S_PLAY;
        end
        S_PLAY: begin
          scan_d = 4'd0;
          // Exit conditions are judged on the registered board so the game
          // freezes for the transition cycle.
          if (mistakes_q >= MAX_M) begin
            state_d = S_LOST;
          end else if (&filled_q) begin
            state_d = S_CHECK;
          end else begin
            do_place = place;
`ifdef SOD_HINT_EN
            if (hint_req) begin
              do_place = 1'b0;
              if (!hint_used_q && !filled_q[cur_idx]) begin
                board_d[row_q][col_q] = cur_key;
                filled_d[cur_idx]     = 1'b1;
                hint_used_d           = 1'b1;
              end
            end
`endif
            if (do_place && !filled_q[cur_idx]) begin
              if (sel == cur_key) begin
                board_d[row_q][col_q] = sel;
                filled_d[cur_idx]     = 1'b1;
              end else if (mistakes_q < MAX_M) begin
                mistakes_d = mistakes_q + 2'd1;
                flash_d    = 1'b1;
              end
            end
            // 2-bit cursor arithmetic gives the mod-4 wrap for free
            if (up)         row_d = row_q - 2'd1;
            else if (down)  row_d = row_q + 2'd1;
            else if (left)  col_d = col_q - 2'd1;
            else if (right) col_d = col_q + 2'd1;
          end
        end
        S_CHECK: begin
          if (board_q[scan_q[3:2]][scan_q[1:0]] != cardArray[scan_q[3:2]][scan_q[1:0]])
            state_d = S_LOST;
          else if (scan_q == 4'd15)
            state_d = S_WON;
          else
            scan_d = scan_q + 4'd1;
        end
        S_WON, S_LOST: begin
          state_d = state_q;
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  assign cursorRow  = row_q;
  assign cursorCol  = col_q;
  assign board      = board_q;
  assign filled     = filled_q;
  assign mistakes   = mistakes_q;
  assign wrongFlash = flash_q;
  assign playing    = (state_q == S_PLAY);
  assign won        = (state_q == S_WON);
  assign lost       = (state_q == S_LOST);
`ifdef SOD_HINT_EN
  assign hintUsed   = hint_used_q;
`endif

endmodule

// File: tb/tb_sod_board_ctrl.sv
// Directed bench for sod_board_ctrl with an expected-value queue.
module tb_sod_board_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic                 reset, newGame, up, down, left, right, place;
  logic [1:0]           sel;
  logic [3:0][3:0][1:0] cardArray, board;
  logic [1:0]           cursorRow, cursorCol, mistakes;
  logic [15:0]          filled;
  logic                 wrongFlash, playing, won, lost;
`ifdef SOD_HINT_EN
  logic                 hint, hintUsed;
`endif

  sod_board_ctrl dut (
    .clk(clk), .reset(reset), .newGame(newGame), .cardArray(cardArray),
    .up(up), .down(down), .left(left), .right(right), .place(place), .sel(sel),
`ifdef SOD_HINT_EN
    .hint, .hintUsed,
`endif
    .cursorRow(cursorRow), .cursorCol(cursorCol), .board(board), .filled(filled),
    .mistakes(mistakes), .wrongFlash(wrongFlash), .playing(playing), .won(won), .lost(lost)
  );

  localparam int M_UP = 1, M_DN = 2, M_LF = 4, M_RT = 8, M_PL = 16, M_NG = 32, M_HT = 64;
  localparam logic [15:0] CLUES = 16'hA5A5;

  int tests = 0;
  int fails = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [3:0][3:0][1:0] key0, key1, eb;
  logic [1:0]  er, ec;
  logic [15:0] ef;

  function automatic logic [31:0] loaded(input logic [3:0][3:0][1:0] k);
    logic [3:0][3:0][1:0] b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = CLUES[r*4+c] ? k[r][c] : 2'b00;
    return 32'(b);
  endfunction

  task automatic expv(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic popc(input logic [31:0] o);
    string t;
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_underflow observed=%0h expected=<none>", o);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic cyc(input int m, input logic [1:0] s);
    up = m[0]; down = m[1]; left = m[2]; right = m[3];
    place = m[4]; newGame = m[5]; sel = s;
`ifdef SOD_HINT_EN
    hint = m[6];
`endif
    @(posedge clk); #1;
    up = 0; down = 0; left = 0; right = 0; place = 0; newGame = 0;
`ifdef SOD_HINT_EN
    hint = 0;
`endif
  endtask

  task automatic goto_cell(input logic [1:0] r, input logic [1:0] c);
    while (er != r) begin cyc(M_DN, 2'd0); er = er + 2'd1; end
    while (ec != c) begin cyc(M_RT, 2'd0); ec = ec + 2'd1; end
  endtask

  task automatic status(input string t, input logic [2:0] pwl);
    expv(t, 32'(pwl));
    popc(32'({playing, won, lost}));
  endtask

  int k0 [4][4] = '{'{0, 3, 1, 2}, '{1, 2, 0, 3}, '{3, 0, 2, 1}, '{2, 1, 3, 0}};
  int rest_r [6] = '{0, 1, 1, 2, 3, 3};
  int rest_c [6] = '{3, 0, 2, 3, 0, 2};

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        key0[r][c] = 2'(k0[r][c]);
        key1[r][c] = 2'(3 - k0[r][c]);
      end
    reset = 0; newGame = 0; up = 0; down = 0; left = 0; right = 0; place = 0; sel = 0;
`ifdef SOD_HINT_EN
    hint = 0;
`endif
    cardArray = key0;

    // reset held two cycles
    expv("rst_status", 32'd0); expv("rst_filled", 32'd0); expv("rst_board", 32'd0);
    expv("rst_cursor", 32'd0); expv("rst_mis_flash", 32'd0);
    repeat (2) @(posedge clk);
    #1;
    popc(32'({playing, won, lost})); popc(32'(filled)); popc(32'(board));
    popc(32'({cursorRow, cursorCol})); popc(32'({mistakes, wrongFlash}));

    // release: LOAD edge then PLAY
    reset = 1;
    eb = loaded(key0); ef = CLUES; er = 0; ec = 0;
    expv("load_filled", 32'(ef)); expv("load_board", 32'(eb)); expv("load_status", 32'(3'b100));
    expv("load_cursor", 32'd0);
    @(posedge clk); #1;
    popc(32'(filled)); popc(32'(board)); popc(32'({playing, won, lost}));
    popc(32'({cursorRow, cursorCol}));

    // move right, correct placement at (0,1)
    expv("mv_right", 32'(4'b0001));
    cyc(M_RT, 2'd0); ec = 1;
    popc(32'({cursorRow, cursorCol}));
    eb[0][1] = 2'd3; ef[1] = 1'b1;
    expv("place_ok_board", 32'(eb)); expv("place_ok_filled", 32'(ef));
    expv("place_ok_noflash", 32'(3'b000));
    cyc(M_PL, 2'd3);
    popc(32'(board)); popc(32'(filled)); popc(32'({mistakes, wrongFlash}));

    // place on an already-filled cell is ignored
    expv("filled_cell_board", 32'(eb)); expv("filled_cell_mis", 32'(3'b000));
    cyc(M_PL, 2'd0);
    popc(32'(board)); popc(32'({mistakes, wrongFlash}));

    // up from row 0 wraps to row 3; up+left moves only the row
    expv("up_wrap", 32'(4'b1101));
    cyc(M_UP, 2'd0); er = 3;
    popc(32'({cursorRow, cursorCol}));
    expv("up_left_prio", 32'(4'b1001));
    cyc(M_UP | M_LF, 2'd0); er = 2;
    popc(32'({cursorRow, cursorCol}));

    // place uses the pre-move cursor while the move also happens
    eb[2][1] = key0[2][1]; ef[9] = 1'b1;
    expv("place_move_board", 32'(eb)); expv("place_move_cursor", 32'(4'b1010));
    cyc(M_PL | M_RT, key0[2][1]); ec = 2;
    popc(32'(board)); popc(32'({cursorRow, cursorCol}));

    // wrong symbol on a clue cell: no mistake
    expv("clue_cell_mis", 32'(3'b000));
    cyc(M_PL, key0[2][2] + 2'd1);
    popc(32'({mistakes, wrongFlash}));

    // fill the remaining cells correctly
    for (int i = 0; i < 6; i++) begin
      goto_cell(2'(rest_r[i]), 2'(rest_c[i]));
      cyc(M_PL, key0[rest_r[i]][rest_c[i]]);
      eb[rest_r[i]][rest_c[i]] = key0[rest_r[i]][rest_c[i]];
      ef[rest_r[i]*4 + rest_c[i]] = 1'b1;
    end
    expv("full_board", 32'(eb)); expv("full_filled", 32'(ef));
    popc(32'(board)); popc(32'(filled));
    status("full_still_play", 3'b100);
    cyc(0, 2'd0);
    status("check_enter", 3'b000);
    repeat (15) cyc(0, 2'd0);
    status("check_16th", 3'b000);
    cyc(0, 2'd0);
    status("won", 3'b010);

    // WON is sticky, inputs ignored
    expv("won_cursor_hold", 32'({er, ec}));
    cyc(M_UP | M_PL, 2'd0);
    popc(32'({cursorRow, cursorCol}));
    status("won_sticky", 3'b010);

    // new game: key advances on the same pulse
    cardArray = key1;
    cyc(M_NG, 2'd0);
    status("ng_load", 3'b000);
    eb = loaded(key1); ef = CLUES; er = 0; ec = 0;
    expv("g1_board", 32'(eb)); expv("g1_filled", 32'(ef)); expv("g1_cursor", 32'd0);
    expv("g1_mis", 32'd0);
    cyc(0, 2'd0);
    popc(32'(board)); popc(32'(filled)); popc(32'({cursorRow, cursorCol})); popc(32'(mistakes));
    status("g1_play", 3'b100);

    // three wrong placements at unfilled (0,1), key is 0
    cyc(M_RT, 2'd0); ec = 1;
    for (int i = 1; i <= 3; i++) begin
      expv("wrong_mis_flash", 32'({2'(i), 1'b1}));
      expv("wrong_board", 32'(eb)); expv("wrong_filled", 32'(ef));
      cyc(M_PL, 2'(i));
      popc(32'({mistakes, wrongFlash})); popc(32'(board)); popc(32'(filled));
      status("wrong_still_play", 3'b100);
      expv("flash_clears", 32'd0);
      cyc(0, 2'd0);
      popc(32'(wrongFlash));
      status("after_wrong", (i == 3) ? 3'b001 : 3'b100);
    end

    // saturation and sticky LOST
    expv("lost_mis_sat", 32'(3'b110));
    cyc(M_PL, 2'd2);
    popc(32'({mistakes, wrongFlash}));
    status("lost_sticky", 3'b001);

    // newGame recovers from LOST
    cardArray = key0;
    cyc(M_NG, 2'd0);
    cyc(0, 2'd0);
    eb = loaded(key0); ef = CLUES; er = 0; ec = 0;
    expv("g2_board", 32'(eb)); expv("g2_mis", 32'd0);
    popc(32'(board)); popc(32'(mistakes));
    status("g2_play", 3'b100);

`ifdef SOD_HINT_EN
    cyc(M_RT, 2'd0); ec = 1;
    eb[0][1] = key0[0][1]; ef[1] = 1'b1;
    expv("hint_board", 32'(eb)); expv("hint_filled", 32'(ef)); expv("hint_used", 32'd1);
    expv("hint_place_ignored", 32'd0);
    cyc(M_HT | M_PL, key0[0][1] + 2'd1);
    popc(32'(board)); popc(32'(filled)); popc({31'd0, hintUsed}); popc(32'(mistakes));
    goto_cell(2'd0, 2'd3);
    expv("hint2_board", 32'(eb)); expv("hint2_filled", 32'(ef));
    cyc(M_HT, 2'd0);
    popc(32'(board)); popc(32'(filled));
`endif

    expv("queue_drained", 32'd0);
    popc(32'(exp_q.size() - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
